// File: rtl/column_step_scheduler.sv
// column_step_scheduler: sequences column time-steps (read sweep, writeback drain, buffer swap) and counts them to a limit.
module column_step_scheduler #(
  parameter int N_ROWS   = 30,
  parameter int ADDR_W   = 5,
  parameter int PIPE_LAT = 2,
  parameter int ITER_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iterations,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              first_node,
  output logic              last_node,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              buf_sel,
  output logic              center_strobe,
  output logic              step_done,
  output logic [ITER_W-1:0] iterations,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, SWAP, DONE} state_t;
  localparam int CW = $clog2((N_ROWS > PIPE_LAT ? N_ROWS : PIPE_LAT) + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ITER_W-1:0] max_q, max_d, iter_q, iter_d, iter_inc;
  logic buf_q, buf_d;
  logic [PIPE_LAT-1:0] wv_q, wv_d;
  logic [ADDR_W-1:0] wa_q [PIPE_LAT];
  logic [ADDR_W-1:0] wa_d [PIPE_LAT];
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    iter_d   = iter_q;
    buf_d    = buf_q;
    iter_inc = iter_q + ITER_W'(1);
    case (state_q)
      IDLE, DONE: if (start) begin
        max_d   = max_iterations;
        iter_d  = '0;
        cnt_d   = '0;
        state_d = max_iterations == '0 ? DONE : READ;
      end
      READ: begin
        cnt_d   = cnt_q == CW'(N_ROWS - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(N_ROWS - 1) ? DRAIN : READ;
      end
      DRAIN: begin
        cnt_d   = cnt_q == CW'(PIPE_LAT - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(PIPE_LAT - 1) ? SWAP : DRAIN;
      end
      SWAP: begin
        iter_d  = iter_inc;
        buf_d   = !buf_q;
        cnt_d   = '0;
        state_d = iter_inc == max_q ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
    // writeback mirrors the read strobe PIPE_LAT cycles later, regardless of state
    wv_d[0] = rd_en;
    wa_d[0] = rd_addr;
    for (int i = 1; i < PIPE_LAT; i++) begin
      wv_d[i] = wv_q[i-1];
      wa_d[i] = wa_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
      iter_q  <= '0;
      buf_q   <= 1'b0;
      wv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      iter_q  <= iter_d;
      buf_q   <= buf_d;
      wv_q    <= wv_d;
    end
    wa_q <= wa_d;
  end
  assign rd_en         = state_q == READ;
  assign rd_addr       = rd_en ? ADDR_W'(cnt_q) : '0;
  assign first_node    = rd_en && rd_addr == '0;
  assign last_node     = rd_en && rd_addr == ADDR_W'(N_ROWS - 1);
  assign wr_en         = wv_q[PIPE_LAT-1];
  assign wr_addr       = wr_en ? wa_q[PIPE_LAT-1] : '0;
  assign center_strobe = wr_en && wr_addr == ADDR_W'(N_ROWS / 2);
  assign step_done     = state_q == SWAP;
  assign busy          = state_q == READ || state_q == DRAIN || state_q == SWAP;
  assign done          = state_q == DONE;
  assign buf_sel       = buf_q;
  assign iterations    = iter_q;
endmodule

// File: tb/tb_column_step_scheduler.sv
// tb_column_step_scheduler: scoreboard-driven bench for column_step_scheduler at default parameters.
module tb_column_step_scheduler;
  localparam int N = 30;
  localparam int LAT = 2;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [31:0] max_iterations = '0;
  logic rd_en, first_node, last_node, wr_en, buf_sel, center_strobe, step_done, busy, done;
  logic [4:0] rd_addr, wr_addr;
  logic [31:0] iterations;
  logic [50:0] all_out;
  int checks = 0, failures = 0;
  int mon_checks = 0, mon_fails = 0;
  typedef struct {int at; logic [4:0] a;} wr_t;
  wr_t sb[$];
  column_step_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .max_iterations(max_iterations),
    .rd_en(rd_en), .rd_addr(rd_addr), .first_node(first_node), .last_node(last_node),
    .wr_en(wr_en), .wr_addr(wr_addr), .buf_sel(buf_sel), .center_strobe(center_strobe),
    .step_done(step_done), .iterations(iterations), .busy(busy), .done(done)
  );
  assign all_out = {rd_en, rd_addr, first_node, last_node, wr_en, wr_addr, buf_sel,
                    center_strobe, step_done, iterations, busy, done};
  always #5 clk = ~clk;
  // scoreboard: each read predicts a write of the same node LAT cycles later
  initial begin
    int lbl, exp_rd;
    wr_t e;
    lbl = 0;
    exp_rd = 0;
    forever begin
      @(negedge clk);
      lbl++;
      if (rd_en) begin
        mon_checks++;
        if (rd_addr !== 5'(exp_rd)) begin
          mon_fails++;
          $display("FAIL rd_seq got=%0d exp=%0d", rd_addr, exp_rd);
        end
        sb.push_back('{lbl + LAT, rd_addr});
        exp_rd = exp_rd == N - 1 ? 0 : exp_rd + 1;
      end
      if (wr_en) begin
        mon_checks++;
        if (sb.size() == 0) begin
          mon_fails++;
          $display("FAIL wr_unexpected got addr=%0d exp=no write", wr_addr);
        end else begin
          e = sb.pop_front();
          if (wr_addr !== e.a || lbl != e.at) begin
            mon_fails++;
            $display("FAIL wr_match got addr=%0d cyc=%0d exp addr=%0d cyc=%0d", wr_addr, lbl, e.a, e.at);
          end
        end
      end
      mon_checks++;
      if (center_strobe !== (wr_en && wr_addr == 5'd15)) begin
        mon_fails++;
        $display("FAIL center got=%b exp=%b", center_strobe, wr_en && wr_addr == 5'd15);
      end
      mon_checks++;
      if (first_node !== (rd_en && rd_addr == 5'd0) || last_node !== (rd_en && rd_addr == 5'd29)) begin
        mon_fails++;
        $display("FAIL boundary got=%b%b addr=%0d rd_en=%b", first_node, last_node, rd_addr, rd_en);
      end
      if (rst) begin
        sb.delete();
        exp_rd = 0;
      end
    end
  end
  task automatic start_run(input logic [31:0] m);
    @(negedge clk);
    start = 1;
    max_iterations = m;
    @(negedge clk);
    start = 0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0", all_out);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=0", all_out);
    end
  endtask
  task automatic test_run10;
    int first_wr = 0, wr30 = 0, wrs = 0, cs = 0, sd = 0, first_sd = 0, tog = 0, done_at = 0;
    logic pb;
    start_run(10);
    pb = buf_sel;
    for (int k = 1; k <= 400 && done_at == 0; k++) begin
      if (k == 1) begin
        checks++;
        if (!(rd_en === 1'b1 && rd_addr === 5'd0 && busy === 1'b1 && done === 1'b0)) begin
          failures++;
          $display("FAIL run_first_read got rd_en=%b addr=%0d busy=%b exp 1/0/1", rd_en, rd_addr, busy);
        end
      end
      if (wr_en) begin
        wrs++;
        if (first_wr == 0) first_wr = k;
        if (wrs == 30) wr30 = k;
      end
      if (center_strobe) cs++;
      if (step_done) begin
        sd++;
        if (first_sd == 0) first_sd = k;
      end
      if (buf_sel !== pb) tog++;
      pb = buf_sel;
      if (k == 34) begin
        checks++;
        if (iterations !== 32'd1 || buf_sel !== 1'b1) begin
          failures++;
          $display("FAIL run_step1 got iter=%0d buf=%b exp iter=1 buf=1", iterations, buf_sel);
        end
      end
      if (done === 1'b1) done_at = k;
      start = (k == 50 || k == 100);
      if (start) max_iterations = 3;
      @(negedge clk);
    end
    start = 0;
    checks++;
    if (first_wr != 3 || wr30 != 32) begin
      failures++;
      $display("FAIL run_wr_window got first=%0d last=%0d exp first=3 last=32", first_wr, wr30);
    end
    checks++;
    if (first_sd != 33) begin
      failures++;
      $display("FAIL run_step_done got=%0d exp=33", first_sd);
    end
    checks++;
    if (done_at != 331) begin
      failures++;
      $display("FAIL run_done_time got=%0d exp=331", done_at);
    end
    checks++;
    if (wrs != 300 || cs != 10 || sd != 10 || tog != 10) begin
      failures++;
      $display("FAIL run_counts got wr=%0d cs=%0d sd=%0d tog=%0d exp 300/10/10/10", wrs, cs, sd, tog);
    end
    checks++;
    if (iterations !== 32'd10 || buf_sel !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL run_final got iter=%0d buf=%b busy=%b done=%b exp 10/0/0/1", iterations, buf_sel, busy, done);
    end
  endtask
  task automatic test_back_to_back;
    int done_at = 0;
    start_run(2);
    checks++;
    if (done !== 1'b0 || iterations !== 32'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_clear got done=%b iter=%0d busy=%b exp 0/0/1", done, iterations, busy);
    end
    for (int k = 1; k <= 100 && done_at == 0; k++) begin
      if (k == 34) begin
        checks++;
        if (buf_sel !== 1'b1 || iterations !== 32'd1) begin
          failures++;
          $display("FAIL b2b_step1 got buf=%b iter=%0d exp 1/1", buf_sel, iterations);
        end
      end
      if (done === 1'b1) done_at = k;
      @(negedge clk);
    end
    checks++;
    if (done_at != 67 || iterations !== 32'd2 || buf_sel !== 1'b0) begin
      failures++;
      $display("FAIL b2b_final got done_at=%0d iter=%0d buf=%b exp 67/2/0", done_at, iterations, buf_sel);
    end
  endtask
  task automatic test_reset_mid;
    int done_at = 0;
    start_run(10);
    for (int k = 1; k < 40; k++) @(negedge clk);
    checks++;
    if (buf_sel !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_prestate got buf=%b busy=%b exp 1/1", buf_sel, busy);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 || iterations !== 32'd0 || buf_sel !== 1'b0) begin
      failures++;
      $display("FAIL mid_abort got busy=%b rd=%b wr=%b iter=%0d buf=%b exp all 0", busy, rd_en, wr_en, iterations, buf_sel);
    end
    @(posedge clk);
    #1 rst = 0;
    start_run(1);
    for (int k = 1; k <= 100 && done_at == 0; k++) begin
      if (done === 1'b1) done_at = k;
      @(negedge clk);
    end
    checks++;
    if (done_at != 34 || iterations !== 32'd1 || buf_sel !== 1'b1) begin
      failures++;
      $display("FAIL mid_rerun got done_at=%0d iter=%0d buf=%b exp 34/1/1", done_at, iterations, buf_sel);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drained got=%0d exp=0", sb.size());
    end
  endtask
  task automatic test_zero;
    int rds = 0, wrs = 0;
    logic b;
    b = buf_sel;
    start_run(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || iterations !== 32'd0) begin
      failures++;
      $display("FAIL zero_done got done=%b busy=%b iter=%0d exp 1/0/0", done, busy, iterations);
    end
    for (int k = 1; k <= 40; k++) begin
      if (rd_en) rds++;
      if (wr_en) wrs++;
      @(negedge clk);
    end
    checks++;
    if (rds != 0 || wrs != 0 || buf_sel !== b || done !== 1'b1) begin
      failures++;
      $display("FAIL zero_idle got rd=%0d wr=%0d buf=%b done=%b exp 0/0/%b/1", rds, wrs, buf_sel, done, b);
    end
  endtask
  initial begin
    test_reset();
    test_run10();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    checks += mon_checks;
    failures += mon_fails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
